// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use and HI/LO-occupancy stalls, taken-branch flushes.
// Optional stall/flush performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_unit #(
    parameter int MULT_LATENCY = 4,
    parameter int DIV_LATENCY  = 32,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemRead_out_from_EX,
    input  logic [4:0]       Rt_out_from_EX,
    input  logic [4:0]       Rs_out_from_IF,
    input  logic [4:0]       Rt_out_from_IF,
    input  logic             Uses_Rt_in_ID,
    input  logic             MulDiv_in_ID,
    input  logic             MulDiv_is_div,
    input  logic             MfHiLo_in_ID,
    input  logic             Branch_taken,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             MulDiv_busy,
    output logic             MulDiv_issue,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int MAX_LAT = (MULT_LATENCY > DIV_LATENCY) ? MULT_LATENCY : DIV_LATENCY;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);
    localparam logic [LAT_W-1:0] MULT_LAT_C = LAT_W'(MULT_LATENCY);
    localparam logic [LAT_W-1:0] DIV_LAT_C  = LAT_W'(DIV_LATENCY);

    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    logic             hilo_stall;
    logic             stall;
    logic             issue;

    assign MulDiv_busy = (cnt_q != '0);
    assign load_use    = MemRead_out_from_EX && (Rt_out_from_EX != 5'd0) &&
                         ((Rt_out_from_EX == Rs_out_from_IF) ||
                          (Uses_Rt_in_ID && (Rt_out_from_EX == Rt_out_from_IF)));
    assign hilo_stall  = MulDiv_busy && (MfHiLo_in_ID || MulDiv_in_ID);
    assign stall       = (load_use || hilo_stall) && !Branch_taken;
    assign issue       = MulDiv_in_ID && !stall && !Branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A busy unit forces hilo_stall, so a load never collides with a decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (issue) begin
            cnt_d = MulDiv_is_div ? DIV_LAT_C : MULT_LAT_C;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - LAT_W'(1);
        end
    end

    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        MulDiv_issue = 1'b0;
        if (!rst) begin
            if (Branch_taken) begin
                IF_ID_Flush  = 1'b1;
                ID_EX_Bubble = 1'b1;
            end else if (stall) begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Bubble = 1'b1;
            end
            MulDiv_issue = issue;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    // Both counters saturate at all-ones rather than wrap.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        if (Branch_taken && !(&flush_count_q)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: load-use, HI/LO occupancy, branch flush, reset and counters.
// A second instance with CNT_W=4 exercises counter saturation when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_unit;

    logic        clk;
    logic        rst;
    logic        mem_rd;
    logic [4:0]  rt_ex, rs_if, rt_if;
    logic        uses_rt, md_id, md_div, mf, br;
    logic        pcw, ifw, bub, fls, busy, iss;
    logic [15:0] stall_cnt, flush_cnt;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int vectors = 0;
    int errors  = 0;
    int es16 = 0, es4 = 0, ef = 0;

    hazard_unit #(.MULT_LATENCY(4), .DIV_LATENCY(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .MemRead_out_from_EX(mem_rd), .Rt_out_from_EX(rt_ex),
        .Rs_out_from_IF(rs_if), .Rt_out_from_IF(rt_if),
        .Uses_Rt_in_ID(uses_rt), .MulDiv_in_ID(md_id), .MulDiv_is_div(md_div),
        .MfHiLo_in_ID(mf), .Branch_taken(br),
        .PCWrite(pcw), .IF_ID_Write(ifw), .ID_EX_Bubble(bub), .IF_ID_Flush(fls),
        .MulDiv_busy(busy), .MulDiv_issue(iss),
        .stall_count(stall_cnt), .flush_count(flush_cnt)
    );

    hazard_unit #(.MULT_LATENCY(4), .DIV_LATENCY(32), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .MemRead_out_from_EX(mem_rd), .Rt_out_from_EX(rt_ex),
        .Rs_out_from_IF(rs_if), .Rt_out_from_IF(rt_if),
        .Uses_Rt_in_ID(uses_rt), .MulDiv_in_ID(md_id), .MulDiv_is_div(md_div),
        .MfHiLo_in_ID(mf), .Branch_taken(br),
        .PCWrite(), .IF_ID_Write(), .ID_EX_Bubble(), .IF_ID_Flush(),
        .MulDiv_busy(), .MulDiv_issue(),
        .stall_count(stall_cnt4), .flush_count(flush_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic p, input logic w, input logic b, input logic f);
        chk({tag, ".PCWrite"}, 32'(pcw), 32'(p));
        chk({tag, ".IF_ID_Write"}, 32'(ifw), 32'(w));
        chk({tag, ".ID_EX_Bubble"}, 32'(bub), 32'(b));
        chk({tag, ".IF_ID_Flush"}, 32'(fls), 32'(f));
    endtask

    task automatic chk_cnt(input string tag);
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, ".stall_count"}, 32'(stall_cnt), 32'(es16));
        chk({tag, ".flush_count"}, 32'(flush_cnt), 32'(ef));
        chk({tag, ".stall_count4"}, 32'(stall_cnt4), 32'(es4));
`else
        chk({tag, ".stall_count"}, 32'(stall_cnt), 32'd0);
        chk({tag, ".flush_count"}, 32'(flush_cnt), 32'd0);
        chk({tag, ".stall_count4"}, 32'(stall_cnt4), 32'd0);
`endif
    endtask

    // Counter model: advances on the edge according to what this cycle was expected to do.
    task automatic tick(input bit st, input bit fl);
        @(posedge clk);
        if (rst) begin
            es16 = 0; es4 = 0; ef = 0;
        end else begin
            if (st && es16 != 65535) es16++;
            if (st && es4 != 15) es4++;
            if (fl) ef++;
        end
        #1;
    endtask

    task automatic idle_in();
        mem_rd = 0; rt_ex = 0; rs_if = 0; rt_if = 0; uses_rt = 0;
        md_id = 0; md_div = 0; mf = 0; br = 0;
    endtask

    initial begin
        idle_in();
        rst = 1;
        // Reset forces idle controls even with a live load-use hazard
        mem_rd = 1; rt_ex = 5'd2; rs_if = 5'd2;
        #1;
        chk_ctl("rst_forced", 1, 1, 0, 0);
        chk("rst_issue", 32'(iss), 32'd0);
        tick(0, 0);
        tick(0, 0);
        idle_in();
        rst = 0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk_ctl("idle", 1, 1, 0, 0);
        chk_cnt("reset");

        // Load-use on rs: one stall, then free flow once the load moves to MEM
        mem_rd = 1; rt_ex = 5'd2; rs_if = 5'd2; #1;
        chk_ctl("lu_rs", 0, 0, 1, 0);
        tick(1, 0);
        mem_rd = 0; #1;
        chk_ctl("lu_after", 1, 1, 0, 0);
        tick(0, 0);

        // Register 0 never stalls
        mem_rd = 1; rt_ex = 5'd0; rs_if = 5'd0; #1;
        chk_ctl("lu_r0", 1, 1, 0, 0);
        tick(0, 0);

        // rt match only counts when ID actually reads rt
        rt_ex = 5'd5; rs_if = 5'd7; rt_if = 5'd5; uses_rt = 0; #1;
        chk_ctl("lu_rt_unused", 1, 1, 0, 0);
        uses_rt = 1; #1;
        chk_ctl("lu_rt_used", 0, 0, 1, 0);
        tick(1, 0);
        chk_cnt("after_lu");

        // Fresh counters so the divide accounts for exactly its own stalls
        idle_in();
        rst = 1; tick(0, 0); rst = 0; #1;

        // Divide issue, then dependent mflo stalls exactly 32 cycles
        md_id = 1; md_div = 1; #1;
        chk("div_issue", 32'(iss), 32'd1);
        chk("div_busy_pre", 32'(busy), 32'd0);
        tick(0, 0);
        idle_in(); mf = 1; #1;
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("div_busy_%0d", i), 32'(busy), 32'd1);
            chk_ctl($sformatf("mflo_stall_%0d", i), 0, 0, 1, 0);
            tick(1, 0);
        end
        chk("div_busy_end", 32'(busy), 32'd0);
        chk_ctl("mflo_go", 1, 1, 0, 0);
        chk_cnt("after_div");
        tick(0, 0);

        // mult, unrelated add, mult: second mult waits out the busy window
        idle_in(); md_id = 1; #1;
        chk("mult1_issue", 32'(iss), 32'd1);
        tick(0, 0);
        md_id = 0; #1;
        chk("add_busy", 32'(busy), 32'd1);
        chk_ctl("add_flow", 1, 1, 0, 0);
        tick(0, 0);
        md_id = 1; #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mult2_wait_%0d", i), 32'(iss), 32'd0);
            chk_ctl($sformatf("mult2_stall_%0d", i), 0, 0, 1, 0);
            tick(1, 0);
        end
        chk("mult2_busy_drop", 32'(busy), 32'd0);
        chk("mult2_issue", 32'(iss), 32'd1);
        chk_ctl("mult2_flow", 1, 1, 0, 0);
        tick(0, 0);
        idle_in(); #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mult2_busy_%0d", i), 32'(busy), 32'd1);
            tick(0, 0);
        end
        chk("mult2_done", 32'(busy), 32'd0);

        // Branch beats load-use and squashes a mult in ID
        mem_rd = 1; rt_ex = 5'd3; rs_if = 5'd3; br = 1; md_id = 1; #1;
        chk_ctl("br_lu", 1, 1, 1, 1);
        chk("br_issue", 32'(iss), 32'd0);
        tick(0, 1);
        idle_in(); #1;
        chk("br_flush_pulse", 32'(fls), 32'd0);
        chk("br_no_busy", 32'(busy), 32'd0);
        chk_cnt("after_br");

        // Reset at cycle 10 of a divide abandons it
        md_id = 1; md_div = 1; #1;
        chk("div2_issue", 32'(iss), 32'd1);
        tick(0, 0);
        idle_in(); mf = 1;
        for (int i = 0; i < 9; i++) tick(1, 0);
        #1;
        chk("div2_busy_c10", 32'(busy), 32'd1);
        rst = 1; #1;
        chk_ctl("div2_rst", 1, 1, 0, 0);
        tick(0, 0);
        rst = 0; #1;
        chk("div2_abandon", 32'(busy), 32'd0);
        chk_ctl("mfhi_go", 1, 1, 0, 0);
        chk_cnt("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
